// File: rtl/jk_drv_pkg.sv
// Shared types for the JK excitation driver: FSM states, JK excitation codes
// and the per-bit excitation lookup.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    DRIVE = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Excitation {J,K} that moves one cell from q to t without using toggle.
  function automatic logic [1:0] jk_code(input logic q, input logic t);
    case ({q, t})
      2'b01:   jk_code = JK_SET;
      2'b10:   jk_code = JK_RST;
      default: jk_code = JK_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/jk_drv_fifo.sv
// Synchronous show-ahead target FIFO; DEPTH is a power of two so the
// pointers wrap naturally.
module jk_drv_fifo
  import jk_drv_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a bank of JK cells to a stream of target vectors, one target per
// drive pulse, and checks the cell feedback against a model of the bank.
module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNT_W    = 8,
  parameter bit          CHECK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_target,
  output logic             in_ready,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             drive_vld,
  input  logic [WIDTH-1:0] q_fb,
  input  logic             clear_err,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] q_model;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] j_nxt;
  logic [WIDTH-1:0] k_nxt;
  logic             full;
  logic             empty;
  logic             pop;
  logic             mismatch;

  assign in_ready = !full;
  assign pop      = (state == IDLE) && !empty;
  assign busy     = (state != IDLE) || !empty;
  assign mismatch = CHECK_EN && (state == CHECK) && (q_fb != q_model);

  jk_drv_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && !full),
    .push_data (in_target),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_exc
    logic [1:0] code;
    assign code     = jk_code(q_model[i], head[i]);
    assign j_nxt[i] = code[1];
    assign k_nxt[i] = code[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      j         <= '0;
      k         <= '0;
      drive_vld <= 1'b0;
      q_model   <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      case (state)
        // Force every cell to 0 so the model starts from a known value.
        INIT: begin
          j         <= '0;
          k         <= '1;
          drive_vld <= 1'b1;
          q_model   <= '0;
          state     <= DRIVE;
        end
        IDLE: begin
          if (!empty) begin
            j         <= j_nxt;
            k         <= k_nxt;
            drive_vld <= 1'b1;
            q_model   <= head;
            state     <= DRIVE;
          end else begin
            j         <= '0;
            k         <= '0;
            drive_vld <= 1'b0;
          end
        end
        DRIVE: begin
          j         <= '0;
          k         <= '0;
          drive_vld <= 1'b0;
          state     <= CHECK_EN ? CHECK : IDLE;
        end
        CHECK: begin
          state <= IDLE;
        end
        default: begin
          state <= INIT;
        end
      endcase

      // A mismatch on the same edge as clear_err restarts the count at 1.
      if (mismatch) begin
        err <= 1'b1;
        if (clear_err)          err_cnt <= CNT_W'(1);
        else if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      end else if (clear_err) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end
    end
  end

endmodule
